// File: rtl/reg_bus_seq_pkg.sv
// Shared types for the register-bus sequencer.
// Command opcodes, FSM states and the default data width.
package reg_bus_seq_pkg;

    localparam int SEQ_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_MOVE = 2'b10,
        OP_READ = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSRD,
        S_WRITE,
        S_RSP,
        S_VERIFY
    } state_t;

endpackage

// File: rtl/seq_onehot_dec.sv
// Register index plus enable to one-hot select vector.
// An index outside the bank decodes to all zeros.
module seq_onehot_dec #(
    parameter int IDXW = 2,
    parameter int NREG = 4
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [NREG-1:0] vec
);

    always_comb begin
        vec = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (idx == IDXW'(i)))
                vec[i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Initiator-side sequencer driving R_W/Ea strobes for a 16-bit register bank.
// Define SEQ_VERIFY_EN to add a read-back VERIFY cycle after every write.
module reg_bus_sequencer
    import reg_bus_seq_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int WIDTH = SEQ_WIDTH,
    parameter int IDXW  = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_src,
    input  logic [IDXW-1:0]  cmd_dst,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [NREG-1:0]  R_W,
    output logic [NREG-1:0]  Ea,
    output logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Qa,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             done,
    output logic             err
);

    localparam logic [31:0] NREG_L = 32'(NREG);

    state_t          state;
    op_t             op_q;
    logic [IDXW-1:0] dst_q;

    op_t             op_in;
    logic            accept;
    logic            src_ok;
    logic            dst_ok;
    logic            idx_ok;

    logic            ea_en;
    logic [IDXW-1:0] ea_idx;
    logic            wr_en;
    logic [IDXW-1:0] wr_idx;
    logic [NREG-1:0] ea_vec;
    logic [NREG-1:0] wr_vec;

    assign op_in  = op_t'(cmd_op);
    assign accept = cmd_valid && cmd_ready;
    assign src_ok = 32'(cmd_src) < NREG_L;
    assign dst_ok = 32'(cmd_dst) < NREG_L;

    always_comb begin
        unique case (op_in)
            OP_LOAD: idx_ok = dst_ok;
            OP_MOVE: idx_ok = src_ok && dst_ok;
            OP_READ: idx_ok = src_ok;
            default: idx_ok = 1'b1;
        endcase
    end

    // Strobe requests for the next cycle, registered below.
    always_comb begin
        ea_en  = 1'b0;
        ea_idx = cmd_src;
        wr_en  = 1'b0;
        wr_idx = dst_q;
        case (state)
            S_IDLE: begin
                if (accept && idx_ok) begin
                    case (op_in)
                        OP_LOAD: begin
                            wr_en  = 1'b1;
                            wr_idx = cmd_dst;
                        end
                        OP_MOVE,
                        OP_READ: ea_en = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_BUSRD: wr_en = (op_q == OP_MOVE);
`ifdef SEQ_VERIFY_EN
            S_WRITE: begin
                ea_en  = 1'b1;
                ea_idx = dst_q;
            end
`endif
            default: ;
        endcase
    end

    seq_onehot_dec #(
        .IDXW(IDXW),
        .NREG(NREG)
    ) u_ea_dec (
        .idx(ea_idx),
        .en (ea_en),
        .vec(ea_vec)
    );

    seq_onehot_dec #(
        .IDXW(IDXW),
        .NREG(NREG)
    ) u_wr_dec (
        .idx(wr_idx),
        .en (wr_en),
        .vec(wr_vec)
    );

    // D doubles as the holding register for bus reads and verify data.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            cmd_ready <= 1'b1;
            R_W       <= '1;
            Ea        <= '0;
            D         <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            R_W  <= ~wr_vec;
            Ea   <= ea_vec;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        dst_q <= cmd_dst;
                        if (!idx_ok) begin
                            err <= 1'b1;
                        end else begin
                            case (op_in)
                                OP_LOAD: begin
                                    state     <= S_WRITE;
                                    D         <= cmd_data;
                                    cmd_ready <= 1'b0;
                                end
                                OP_MOVE,
                                OP_READ: begin
                                    state     <= S_BUSRD;
                                    cmd_ready <= 1'b0;
                                end
                                default: done <= 1'b1;
                            endcase
                        end
                    end
                end
                S_BUSRD: begin
                    if (op_q == OP_MOVE) begin
                        state <= S_WRITE;
                        D     <= Qa;
                    end else begin
                        state     <= S_RSP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= Qa;
                    end
                end
                S_WRITE: begin
`ifdef SEQ_VERIFY_EN
                    state <= S_VERIFY;
`else
                    state     <= S_IDLE;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
`endif
                end
`ifdef SEQ_VERIFY_EN
                S_VERIFY: begin
                    state     <= S_IDLE;
                    done      <= 1'b1;
                    err       <= (Qa != D);
                    cmd_ready <= 1'b1;
                end
`endif
                S_RSP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Directed bench for reg_bus_sequencer with a behavioural 4-register bank.
// IDXW is widened to 3 so out-of-range indices can be offered.
module tb_reg_bus_sequencer;
    import reg_bus_seq_pkg::*;

`ifdef SEQ_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif

    logic        CLK;
    logic        CLR;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_src;
    logic [2:0]  cmd_dst;
    logic [15:0] cmd_data;
    logic [3:0]  R_W;
    logic [3:0]  Ea;
    logic [15:0] D;
    logic [15:0] Qa;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        done;
    logic        err;

    logic [15:0] bank [4];
    logic        fault;
    int          n_checks;
    int          n_errors;
    logic        mon_en;

    reg_bus_sequencer #(
        .NREG (4),
        .WIDTH(16),
        .IDXW (3)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_src  (cmd_src),
        .cmd_dst  (cmd_dst),
        .cmd_data (cmd_data),
        .R_W      (R_W),
        .Ea       (Ea),
        .D        (D),
        .Qa       (Qa),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .done     (done),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (R_W[i] == 1'b0)
                bank[i] <= D;
    end

    always_comb begin
        Qa = '0;
        for (int i = 0; i < 4; i++)
            if (Ea[i])
                Qa = Qa | bank[i];
        if (fault)
            Qa[0] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en)
            check("strobe_excl",
                  {29'd0, $countones(Ea) <= 1, $countones(~R_W) <= 1,
                   !((|Ea) && !(&R_W))},
                  32'd7);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] src,
                        input logic [2:0] dst, input logic [15:0] data);
        check("send_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_src   = ~src;
        cmd_dst   = ~dst;
        cmd_data  = ~data;
    endtask

    task automatic wait_done(input string tag, input int cur, input int lat);
        int c;
        c = cur;
        while (done !== 1'b1 && c < cur + 20) begin
            tick();
            c++;
        end
        check(tag, 32'(c), 32'(lat));
    endtask

    task automatic do_load(input logic [2:0] dst, input logic [15:0] data);
        send(OP_LOAD, 3'd0, dst, data);
        wait_done("load_lat", 1, 2 + VX);
    endtask

    task automatic do_read(input logic [2:0] src, input logic [15:0] exp);
        rsp_ready = 1'b1;
        send(OP_READ, src, 3'd0, 16'h0);
        tick();
        check("read_valid", {31'd0, rsp_valid}, 32'd1);
        check("read_data", {16'd0, rsp_data}, {16'd0, exp});
        wait_done("read_lat", 2, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=hang exp=finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        fault     = 1'b0;
        CLR       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();

        check("rst_rw", {28'd0, R_W}, 32'hF);
        check("rst_ea", {28'd0, Ea}, 32'h0);
        check("rst_d", {16'd0, D}, 32'h0);
        check("rst_rdata", {16'd0, rsp_data}, 32'h0);
        check("rst_flags", {28'd0, rsp_valid, done, err, cmd_ready}, 32'h1);

        CLR    = 1'b1;
        mon_en = 1'b1;
        tick();

        // LOAD dst=2
        send(OP_LOAD, 3'd0, 3'd2, 16'hA5C3);
        check("ld_rw", {28'd0, R_W}, 32'hB);
        check("ld_d", {16'd0, D}, 32'hA5C3);
        check("ld_busy", {31'd0, cmd_ready}, 32'd0);
        check("ld_nodone", {31'd0, done}, 32'd0);
        tick();
        check("ld_rw_off", {28'd0, R_W}, 32'hF);
        wait_done("ld_lat", 2, 2 + VX);
        check("ld_ready_done", {31'd0, cmd_ready}, 32'd1);
        check("ld_d_hold", {16'd0, D}, 32'hA5C3);

        // back-to-back READ in the done cycle
        rsp_ready = 1'b1;
        send(OP_READ, 3'd2, 3'd0, 16'h0);
        check("rd_ea", {28'd0, Ea}, 32'h4);
        check("rd_rw", {28'd0, R_W}, 32'hF);
        tick();
        check("rd_ea_off", {28'd0, Ea}, 32'h0);
        check("rd_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_data", {16'd0, rsp_data}, 32'hA5C3);
        wait_done("rd_lat", 2, 3);
        check("rd_valid_off", {31'd0, rsp_valid}, 32'd0);

        // MOVE r0 -> r3
        do_load(3'd0, 16'h1234);
        send(OP_MOVE, 3'd0, 3'd3, 16'hFFFF);
        check("mv_ea", {28'd0, Ea}, 32'h1);
        check("mv_rw1", {28'd0, R_W}, 32'hF);
        tick();
        check("mv_ea2", {28'd0, Ea}, 32'h0);
        check("mv_rw2", {28'd0, R_W}, 32'h7);
        check("mv_d", {16'd0, D}, 32'h1234);
        wait_done("mv_lat", 2, 3 + VX);
        do_read(3'd3, 16'h1234);

        // MOVE with src == dst
        send(OP_MOVE, 3'd2, 3'd2, 16'h0);
        wait_done("mv_same_lat", 1, 3 + VX);
        do_read(3'd2, 16'hA5C3);

        // READ with stalled consumer
        do_load(3'd1, 16'hBEEF);
        rsp_ready = 1'b0;
        send(OP_READ, 3'd1, 3'd0, 16'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", {16'd0, rsp_data}, 32'hBEEF);
            check("stall_busy", {30'd0, cmd_ready, done}, 32'd0);
            tick();
        end
        check("stall_valid_end", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_valid_off", {31'd0, rsp_valid}, 32'd0);
        tick();

        // NOP
        send(OP_NOP, 3'd0, 3'd0, 16'h0);
        check("nop_done", {31'd0, done}, 32'd1);
        check("nop_strobes", {24'd0, R_W, Ea}, 32'hF0);
        check("nop_err", {31'd0, err}, 32'd0);
        tick();

        // illegal indices
        send(OP_LOAD, 3'd0, 3'd5, 16'hDEAD);
        check("bad_ld_err", {31'd0, err}, 32'd1);
        check("bad_ld_strobes", {24'd0, R_W, Ea}, 32'hF0);
        check("bad_ld_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        check("bad_ld_err_off", {31'd0, err}, 32'd0);
        send(OP_MOVE, 3'd7, 3'd0, 16'h0);
        check("bad_mv_err", {31'd0, err}, 32'd1);
        check("bad_mv_strobes", {24'd0, R_W, Ea}, 32'hF0);
        tick();
        send(OP_READ, 3'd4, 3'd0, 16'h0);
        check("bad_rd_err", {31'd0, err}, 32'd1);
        check("bad_rd_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        do_read(3'd0, 16'h1234);

        // reset asserted in the WRITE cycle of a MOVE
        send(OP_MOVE, 3'd1, 3'd3, 16'h0);
        tick();
        check("rstmv_rw", {28'd0, R_W}, 32'h7);
        #2;
        CLR = 1'b0;
        #1;
        check("rstmv_rw_async", {28'd0, R_W}, 32'hF);
        check("rstmv_ea_async", {28'd0, Ea}, 32'h0);
        check("rstmv_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        CLR = 1'b1;
        tick();
        do_read(3'd3, 16'h1234);

`ifdef SEQ_VERIFY_EN
        fault = 1'b1;
        send(OP_LOAD, 3'd0, 3'd0, 16'h0001);
        tick();
        check("vf_ea", {28'd0, Ea}, 32'h1);
        tick();
        check("vf_done_err", {30'd0, done, err}, 32'd3);
        fault = 1'b0;
        tick();
`endif

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
- Initiator-side controller for a bank of 16-bit bus registers. Each register holds when R_W=1, loads D on the clock edge when R_W=0, and drives Qa only while its Ea=1.
- Accepts transfer commands over a valid/ready handshake and generates per-register R_W/Ea strobes.
- Samples the wired-OR Qa bus and returns read data.
- Sits between the datapath control unit and the register bank.

Parameters:
- NREG, 4, number of registers in the bank (2..16)
- WIDTH, 16, data width of D/Qa
- IDXW, $clog2(NREG), register index width

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00=NOP, 01=LOAD (cmd_data->dst), 10=MOVE (src->dst), 11=READ (src->rsp)
- cmd_src  in  IDXW  source register index
- cmd_dst  in  IDXW  destination register index
- cmd_data  in  WIDTH  immediate for LOAD
- R_W  out  NREG  per-register write control, 0=write, 1=hold
- Ea  out  NREG  per-register bus output enable, one-hot or zero
- D  out  WIDTH  write data to the bank
- Qa  in  WIDTH  OR of all register Qa outputs
- rsp_valid  out  1  READ result available
- rsp_ready  in  1  consumer takes the result
- rsp_data  out  WIDTH  READ result
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse on an illegal index (or a verify mismatch)

Behaviour:
- Clock CLK; reset CLR is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - R_W all 1, Ea all 0, D=0, rsp_data=0.
  - rsp_valid=0, done=0, err=0.
  - cmd_ready=1, state IDLE.
- Reset asserted mid-operation forces these values immediately. No partial write may occur: R_W returns to 1 asynchronously.
- States: IDLE, BUSRD, WRITE, RSP (plus VERIFY with the optional feature).
- cmd_ready=1 only in IDLE. A command is accepted on a rising edge where cmd_valid & cmd_ready.
- Accepted command fields are latched; later changes on the cmd_* inputs are ignored.
- NOP: accepted, done pulses the next cycle, no strobes.
- Index check at accept: any used index >= NREG -> err pulses the next cycle, no R_W/Ea activity, stay in IDLE.
- LOAD:
  - Cycle 1 is WRITE: R_W[dst]=0, D=cmd_data.
  - The register captures at the end of cycle 1.
  - Cycle 2: IDLE, done=1.
  - Latency is 2 cycles from accept to done.
- MOVE:
  - Cycle 1 is BUSRD: Ea[src]=1; Qa is latched into the internal holding register at the end of the cycle.
  - Cycle 2 is WRITE: Ea=0, R_W[dst]=0, D=held value.
  - Cycle 3: done.
  - Ea and R_W are never both active in the same cycle.
  - src==dst is legal and rewrites the same value.
- READ:
  - Cycle 1 is BUSRD: Ea[src]=1.
  - Cycle 2 is RSP: rsp_valid=1 and rsp_data=sampled value.
  - rsp_valid and rsp_data hold stable until a rising edge with rsp_ready=1. That edge returns the state to IDLE and produces the done pulse in the following cycle.
  - If rsp_ready=1 in the first RSP cycle, the total latency is 3 cycles.
- Strobes are low at all other times: R_W=all 1 and Ea=0 outside WRITE/BUSRD.
- At most one R_W bit is 0 and at most one Ea bit is 1 in any cycle.
- D holds its last driven value when idle.
- Back-to-back: a new command can be accepted on the same edge at which done is asserted. cmd_ready returns high in that cycle.

Optional Feature:
- Macro: SEQ_VERIFY_EN.
- Defined:
  - After WRITE (LOAD and MOVE), a VERIFY cycle asserts Ea[dst]=1 and compares Qa with the written value.
  - Mismatch -> err=1 together with done.
  - Adds 1 cycle: LOAD 3 cycles, MOVE 4 cycles.
- Undefined: no VERIFY state; err signals only illegal indices.

Decomposition:
- Package reg_bus_seq_pkg contains:
  - the op_t enum (NOP/LOAD/MOVE/READ)
  - the state_t enum
  - the WIDTH default constant
- Sub-module seq_onehot_dec(IDXW, NREG): index plus enable -> one-hot vector. It is instanced twice: for Ea (src) and for the R_W write-select (dst, inverted).

Test Plan:
- Reset mid-MOVE: assert CLR low during the WRITE cycle -> R_W=4'b1111 and Ea=0 immediately; dst contents unchanged.
- LOAD dst=2, data=16'hA5C3 -> R_W=4'b1011 for exactly one cycle, D=A5C3; done 2 cycles after accept; a subsequent READ of src=2 returns A5C3.
- MOVE src=0 (holding 16'h1234), dst=3 -> Ea=4'b0001 in cycle 1 and R_W=4'b0111 in cycle 2, never overlapping; register 3 then reads 1234.
- READ src=1 with rsp_ready held low for 5 cycles -> rsp_valid stays 1 and rsp_data stays stable; cmd_ready=0 throughout; the command completes one cycle after rsp_ready rises.
- Illegal index: NREG=4 with IDXW widened by the bench, or NREG=3 with dst=3 -> err pulse, no strobes, cmd_ready=1 the next cycle.
- SEQ_VERIFY_EN with a bench-injected bus fault (Qa bit 0 stuck at 0) after LOAD 16'h0001 -> err and done asserted together 3 cycles after accept.
